memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Consumes the execute-to-memory pipeline register: ALU result, store data, destination register, control bits, branch target and zero flag.
- Performs loads and stores over a valid/data_ok data-bus handshake and stalls the pipeline while an access is outstanding.
- Resolves branches.
- Drives the memory-to-writeback register and the EX-stage forwarding source (aluout, plus its dest register and write enable for the hazard unit).

Parameters:
- STALL_LIMIT, 0: bus-wait cycles before bus_err is raised; 0 disables the check.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- e_valid  in  1  execute output holds a real instruction
- e_alu_result  in  32  address or ALU value
- e_write_data  in  32  store data (already forwarded)
- e_write_reg  in  5  destination register
- e_reg_write  in  1  register write enable
- e_mem_to_reg  in  1  load
- e_mem_write  in  1  store
- e_branch  in  1  branch instruction
- e_zero  in  1  ALU zero flag
- e_pc_branch  in  32  branch target
- dreq_valid  out  1  data request valid
- dreq_addr  out  32  word-aligned address
- dreq_strobe  out  4  byte strobe: 4'hF store, 4'h0 load
- dreq_data  out  32  store data
- dresp_data_ok  in  1  request accepted/completed this cycle
- dresp_data  in  32  load data, valid with data_ok
- m_stall  out  1  hold fetch/decode/execute registers
- pc_src  out  1  take branch
- pc_branch  out  32  branch target
- fwd_aluout  out  32  forwarding value
- fwd_write_reg  out  5  forwarding destination
- fwd_reg_write  out  1  forwarding write enable
- w_valid  out  1  writeback register valid
- w_alu_result  out  32  to writeback
- w_read_data  out  32  to writeback
- w_write_reg  out  5  to writeback
- w_reg_write  out  1  to writeback
- w_mem_to_reg  out  1  to writeback

Behaviour:
- Stage register (m_*) loads all e_* on posedge clk when m_stall=0. It holds while m_stall=1.
- Reset clears the stage register, all w_* outputs, the FSM (to IDLE), the wait counter and bus_err.
- All outputs are 0 during and immediately after reset.
- Memory operation: mem_op = m_valid & (m_mem_to_reg | m_mem_write).
- FSM states:
  - IDLE: if mem_op, assert dreq_valid combinationally. If dresp_data_ok is also high, the access completes this cycle (zero-wait) and m_stall=0. Otherwise m_stall=1 and the FSM goes to WAIT.
  - WAIT: dreq_valid=1; dreq_addr, dreq_strobe and dreq_data stay stable from the stage register; m_stall=1. On dresp_data_ok, m_stall=0 and the FSM returns to IDLE.
- dreq_addr = {m_alu_result[31:2], 2'b00}. dreq_data = m_write_data.
- Non-memory or invalid instruction: no request, m_stall=0, latency one cycle through the stage.
- A load captures dresp_data into w_read_data on the completing edge. For non-loads, w_read_data = 0.
- w_* register update:
  - Loads the stage contents on every edge where m_stall=0.
  - w_valid = m_valid on such an edge.
  - When m_stall=1, w_valid is cleared to 0 (bubble) and the other w_* fields are don't-care.
- pc_src = m_valid & m_branch & m_zero & ~m_stall; pc_branch = m_pc_branch.
- The branch signal pulses only in the cycle the instruction leaves the stage, never during a stall.
- fwd_aluout = m_alu_result, fwd_write_reg = m_write_reg, fwd_reg_write = m_valid & m_reg_write. These are valid even while stalled.
- Wait counter:
  - Increments in WAIT.
  - Clears when a request completes.
  - When STALL_LIMIT≠0 and the counter reaches STALL_LIMIT, bus_err goes to 1 and stays sticky until reset. The request stays asserted.
- Asynchronous reset mid-WAIT: dreq_valid drops immediately; the outstanding access is abandoned.

Test Plan:
- ALU op e_alu_result=0x1234, write_reg=5, reg_write=1 → next edge fwd_aluout=0x1234; following edge w_valid=1, w_alu_result=0x1234, w_write_reg=5; dreq_valid never 1.
- Load addr 0x1003, data_ok same cycle, dresp_data=0xDEADBEEF → dreq_addr=0x1000, strobe=0, m_stall=0; next edge w_read_data=0xDEADBEEF, w_mem_to_reg=1.
- Store addr 0x2000, data 0xA5A5A5A5, data_ok after 3 cycles → m_stall=1 for 3 cycles; dreq_* stable with strobe=4'hF; w_valid=0 during the stall; completes on cycle 4.
- Branch with zero=1, target 0x400 → pc_src=1 for exactly one cycle, pc_branch=0x400; zero=0 → pc_src stays 0.
- STALL_LIMIT=4 with data_ok withheld → bus_err=1 after 4 WAIT cycles and held; reset clears it.
- Reset asserted mid-WAIT → dreq_valid, m_stall and w_valid are 0 in the same cycle; after release, the next ALU op flows normally.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage.
// Holds the execute-to-memory register, runs loads/stores over a
// valid/data_ok data-bus handshake, stalls upstream while an access is
// outstanding, resolves branches and drives the writeback register.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   e_*                        execute-stage results entering this stage
//   dreq_*, dresp_*            data-bus request / response
//   m_stall                    hold fetch/decode/execute registers
//   pc_src, pc_branch          taken-branch redirect
//   fwd_*                      forwarding source for the execute stage
//   w_*                        memory-to-writeback register
//   bus_err                    sticky bus-timeout flag
module memory_stage #(
  parameter int unsigned STALL_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [31:0] e_alu_result,
  input  logic [31:0] e_write_data,
  input  logic [4:0]  e_write_reg,
  input  logic        e_reg_write,
  input  logic        e_mem_to_reg,
  input  logic        e_mem_write,
  input  logic        e_branch,
  input  logic        e_zero,
  input  logic [31:0] e_pc_branch,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic        m_stall,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic [31:0] fwd_aluout,
  output logic [4:0]  fwd_write_reg,
  output logic        fwd_reg_write,
  output logic        w_valid,
  output logic [31:0] w_alu_result,
  output logic [31:0] w_read_data,
  output logic [4:0]  w_write_reg,
  output logic        w_reg_write,
  output logic        w_mem_to_reg,
  output logic        bus_err
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 32;

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               bus_err_q, bus_err_d;

  logic               m_valid_q, m_valid_d;
  logic [XLEN-1:0]    m_alu_result_q, m_alu_result_d;
  logic [XLEN-1:0]    m_write_data_q, m_write_data_d;
  logic [REG_W-1:0]   m_write_reg_q, m_write_reg_d;
  logic               m_reg_write_q, m_reg_write_d;
  logic               m_mem_to_reg_q, m_mem_to_reg_d;
  logic               m_mem_write_q, m_mem_write_d;
  logic               m_branch_q, m_branch_d;
  logic               m_zero_q, m_zero_d;
  logic [XLEN-1:0]    m_pc_branch_q, m_pc_branch_d;

  logic               w_valid_q, w_valid_d;
  logic [XLEN-1:0]    w_alu_result_q, w_alu_result_d;
  logic [XLEN-1:0]    w_read_data_q, w_read_data_d;
  logic [REG_W-1:0]   w_write_reg_q, w_write_reg_d;
  logic               w_reg_write_q, w_reg_write_d;
  logic               w_mem_to_reg_q, w_mem_to_reg_d;

  logic               mem_op;
  logic               mem_done;

  // A request is outstanding whenever a valid load/store sits in the stage.
  assign mem_op   = m_valid_q & (m_mem_to_reg_q | m_mem_write_q);
  assign mem_done = mem_op & dresp_data_ok;
  assign m_stall  = mem_op & ~dresp_data_ok;

  // Bus request driven straight from the held stage register.
  assign dreq_valid  = mem_op;
  assign dreq_addr   = {m_alu_result_q[XLEN-1:2], 2'b00};
  assign dreq_strobe = (mem_op & m_mem_write_q) ? 4'hF : 4'h0;
  assign dreq_data   = m_write_data_q;

  // Branch redirect only in the cycle the instruction leaves the stage.
  assign pc_src    = m_valid_q & m_branch_q & m_zero_q & ~m_stall;
  assign pc_branch = m_pc_branch_q;

  assign fwd_aluout    = m_alu_result_q;
  assign fwd_write_reg = m_write_reg_q;
  assign fwd_reg_write = m_valid_q & m_reg_write_q;

  assign w_valid      = w_valid_q;
  assign w_alu_result = w_alu_result_q;
  assign w_read_data  = w_read_data_q;
  assign w_write_reg  = w_write_reg_q;
  assign w_reg_write  = w_reg_write_q;
  assign w_mem_to_reg = w_mem_to_reg_q;
  assign bus_err      = bus_err_q;

  // Handshake FSM, wait counter and sticky timeout flag.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: if (m_stall) state_d = S_WAIT;
      S_WAIT: begin
        if (dresp_data_ok) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q != {CNT_W{1'b1}}) begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (mem_done) wait_cnt_d = '0;
    if ((STALL_LIMIT != 0) && (wait_cnt_d >= CNT_W'(STALL_LIMIT))) bus_err_d = 1'b1;
  end

  // Stage register: advances only when not stalled.
  always_comb begin
    m_valid_d      = m_valid_q;
    m_alu_result_d = m_alu_result_q;
    m_write_data_d = m_write_data_q;
    m_write_reg_d  = m_write_reg_q;
    m_reg_write_d  = m_reg_write_q;
    m_mem_to_reg_d = m_mem_to_reg_q;
    m_mem_write_d  = m_mem_write_q;
    m_branch_d     = m_branch_q;
    m_zero_d       = m_zero_q;
    m_pc_branch_d  = m_pc_branch_q;
    if (!m_stall) begin
      m_valid_d      = e_valid;
      m_alu_result_d = e_alu_result;
      m_write_data_d = e_write_data;
      m_write_reg_d  = e_write_reg;
      m_reg_write_d  = e_reg_write;
      m_mem_to_reg_d = e_mem_to_reg;
      m_mem_write_d  = e_mem_write;
      m_branch_d     = e_branch;
      m_zero_d       = e_zero;
      m_pc_branch_d  = e_pc_branch;
    end
  end

  // Writeback register: bubble while stalled, load data captured on completion.
  always_comb begin
    w_valid_d      = 1'b0;
    w_alu_result_d = w_alu_result_q;
    w_read_data_d  = w_read_data_q;
    w_write_reg_d  = w_write_reg_q;
    w_reg_write_d  = w_reg_write_q;
    w_mem_to_reg_d = w_mem_to_reg_q;
    if (!m_stall) begin
      w_valid_d      = m_valid_q;
      w_alu_result_d = m_alu_result_q;
      w_read_data_d  = (m_valid_q & m_mem_to_reg_q) ? dresp_data : '0;
      w_write_reg_d  = m_write_reg_q;
      w_reg_write_d  = m_reg_write_q;
      w_mem_to_reg_d = m_mem_to_reg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wait_cnt_q     <= '0;
      bus_err_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      m_alu_result_q <= '0;
      m_write_data_q <= '0;
      m_write_reg_q  <= '0;
      m_reg_write_q  <= 1'b0;
      m_mem_to_reg_q <= 1'b0;
      m_mem_write_q  <= 1'b0;
      m_branch_q     <= 1'b0;
      m_zero_q       <= 1'b0;
      m_pc_branch_q  <= '0;
      w_valid_q      <= 1'b0;
      w_alu_result_q <= '0;
      w_read_data_q  <= '0;
      w_write_reg_q  <= '0;
      w_reg_write_q  <= 1'b0;
      w_mem_to_reg_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      bus_err_q      <= bus_err_d;
      m_valid_q      <= m_valid_d;
      m_alu_result_q <= m_alu_result_d;
      m_write_data_q <= m_write_data_d;
      m_write_reg_q  <= m_write_reg_d;
      m_reg_write_q  <= m_reg_write_d;
      m_mem_to_reg_q <= m_mem_to_reg_d;
      m_mem_write_q  <= m_mem_write_d;
      m_branch_q     <= m_branch_d;
      m_zero_q       <= m_zero_d;
      m_pc_branch_q  <= m_pc_branch_d;
      w_valid_q      <= w_valid_d;
      w_alu_result_q <= w_alu_result_d;
      w_read_data_q  <= w_read_data_d;
      w_write_reg_q  <= w_write_reg_d;
      w_reg_write_q  <= w_reg_write_d;
      w_mem_to_reg_q <= w_mem_to_reg_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed table vectors, multi-cycle corner
// sequences and random traffic checked against a cycle-level reference model.
module tb_memory_stage;

  localparam int unsigned LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        e_valid;
  logic [31:0] e_alu_result, e_write_data, e_pc_branch;
  logic [4:0]  e_write_reg;
  logic        e_reg_write, e_mem_to_reg, e_mem_write, e_branch, e_zero;
  logic        dreq_valid;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  logic        m_stall, pc_src;
  logic [31:0] pc_branch, fwd_aluout;
  logic [4:0]  fwd_write_reg;
  logic        fwd_reg_write;
  logic        w_valid;
  logic [31:0] w_alu_result, w_read_data;
  logic [4:0]  w_write_reg;
  logic        w_reg_write, w_mem_to_reg;
  logic        bus_err;

  memory_stage #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .e_valid(e_valid), .e_alu_result(e_alu_result), .e_write_data(e_write_data),
    .e_write_reg(e_write_reg), .e_reg_write(e_reg_write), .e_mem_to_reg(e_mem_to_reg),
    .e_mem_write(e_mem_write), .e_branch(e_branch), .e_zero(e_zero),
    .e_pc_branch(e_pc_branch),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe),
    .dreq_data(dreq_data), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .m_stall(m_stall), .pc_src(pc_src), .pc_branch(pc_branch),
    .fwd_aluout(fwd_aluout), .fwd_write_reg(fwd_write_reg), .fwd_reg_write(fwd_reg_write),
    .w_valid(w_valid), .w_alu_result(w_alu_result), .w_read_data(w_read_data),
    .w_write_reg(w_write_reg), .w_reg_write(w_reg_write), .w_mem_to_reg(w_mem_to_reg),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the instruction held in the stage and the writeback view.
  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic        regw, load, store, br, zero;
    logic [31:0] target;
  } ins_t;

  ins_t        md;
  logic        mw_valid;
  logic [31:0] mw_alu, mw_rd;
  logic [4:0]  mw_wreg;
  logic        mw_regw, mw_m2r;
  int          stall_run;
  logic        merr;

  typedef struct {
    string       name;
    logic [31:0] alu, wdata;
    logic [4:0]  wreg;
    logic        regw, load, store, br, zero;
    logic [31:0] target, rdata;
    logic        x_dvalid;
    logic [31:0] x_addr;
    logic [3:0]  x_strobe;
    logic        x_pc_src;
    logic [31:0] x_w_rd;
    logic        x_w_m2r;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    md        = '{valid: 1'b0, alu: '0, wdata: '0, wreg: '0, regw: 1'b0,
                  load: 1'b0, store: 1'b0, br: 1'b0, zero: 1'b0, target: '0};
    mw_valid  = 1'b0;
    mw_alu    = '0;
    mw_rd     = '0;
    mw_wreg   = '0;
    mw_regw   = 1'b0;
    mw_m2r    = 1'b0;
    stall_run = 0;
    merr      = 1'b0;
  endtask

  function automatic logic mdl_mem();
    return md.valid && (md.load || md.store);
  endfunction

  // Compare every DUT output against the model for the current cycle.
  task automatic settle_check();
    logic mem, stall;
    #1;
    mem   = mdl_mem();
    stall = mem && !dresp_data_ok;
    chk("dreq_valid", 32'(dreq_valid), 32'(mem));
    if (mem) begin
      chk("dreq_addr", dreq_addr, md.alu & 32'hFFFF_FFFC);
      chk("dreq_strobe", 32'(dreq_strobe), md.store ? 32'hF : 32'h0);
      chk("dreq_data", dreq_data, md.wdata);
    end
    chk("m_stall", 32'(m_stall), 32'(stall));
    chk("pc_src", 32'(pc_src), 32'(md.valid && md.br && md.zero && !stall));
    chk("pc_branch", pc_branch, md.target);
    chk("fwd_aluout", fwd_aluout, md.alu);
    chk("fwd_write_reg", 32'(fwd_write_reg), 32'(md.wreg));
    chk("fwd_reg_write", 32'(fwd_reg_write), 32'(md.valid && md.regw));
    chk("w_valid", 32'(w_valid), 32'(mw_valid));
    if (mw_valid) begin
      chk("w_alu_result", w_alu_result, mw_alu);
      chk("w_read_data", w_read_data, mw_rd);
      chk("w_write_reg", 32'(w_write_reg), 32'(mw_wreg));
      chk("w_reg_write", 32'(w_reg_write), 32'(mw_regw));
      chk("w_mem_to_reg", 32'(w_mem_to_reg), 32'(mw_m2r));
    end
    chk("bus_err", 32'(bus_err), 32'(merr));
  endtask

  // Apply the stage rules for the coming edge, then step to the next negedge.
  task automatic advance();
    logic stall;
    if (!reset) begin
      stall = mdl_mem() && !dresp_data_ok;
      if (!stall) begin
        mw_valid  = md.valid;
        mw_alu    = md.alu;
        mw_rd     = (md.valid && md.load) ? dresp_data : 32'h0;
        mw_wreg   = md.wreg;
        mw_regw   = md.regw;
        mw_m2r    = md.load;
        md        = '{valid: e_valid, alu: e_alu_result, wdata: e_write_data,
                      wreg: e_write_reg, regw: e_reg_write, load: e_mem_to_reg,
                      store: e_mem_write, br: e_branch, zero: e_zero, target: e_pc_branch};
        stall_run = 0;
      end else begin
        mw_valid  = 1'b0;
        stall_run++;
        // First stalled edge enters the wait state; later ones are wait cycles.
        if ((LIMIT != 0) && (stall_run - 1 >= int'(LIMIT))) merr = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] wr, input logic rw, input logic ld, input logic st,
                       input logic br, input logic z, input logic [31:0] tgt);
    e_valid      = v;
    e_alu_result = alu;
    e_write_data = wd;
    e_write_reg  = wr;
    e_reg_write  = rw;
    e_mem_to_reg = ld;
    e_mem_write  = st;
    e_branch     = br;
    e_zero       = z;
    e_pc_branch  = tgt;
  endtask

  initial begin
    // name, alu, wdata, wreg, regw, load, store, br, zero, target, rdata,
    // exp: dreq_valid, dreq_addr, strobe, pc_src, w_read_data, w_mem_to_reg
    vecs[0] = '{"alu",      32'h0000_1234, 32'h0,         5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0,
                1'b0, 32'h0,         4'h0, 1'b0, 32'h0,         1'b0};
    vecs[1] = '{"load",     32'h0000_1003, 32'h0,         5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'hDEAD_BEEF,
                1'b1, 32'h0000_1000, 4'h0, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[2] = '{"store",    32'h0000_2000, 32'hA5A5_A5A5, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h1111_1111,
                1'b1, 32'h0000_2000, 4'hF, 1'b0, 32'h0,         1'b0};
    vecs[3] = '{"br_taken", 32'h0,         32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0,
                1'b0, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0};
    vecs[4] = '{"br_not",   32'h5,         32'h0,         5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0,
                1'b0, 32'h0,         4'h0, 1'b0, 32'h0,         1'b0};
    vecs[5] = '{"load_hi",  32'hFFFF_FFFF, 32'h0,         5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0BAD_F00D,
                1'b1, 32'hFFFF_FFFC, 4'h0, 1'b0, 32'h0BAD_F00D, 1'b1};

    reset         = 1'b1;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    model_reset();

    // Reset: everything zero during and right after reset.
    @(negedge clk);
    settle_check();
    advance();
    reset = 1'b0;
    settle_check();
    chk("rst_w_alu_result", w_alu_result, 32'h0);
    chk("rst_w_read_data", w_read_data, 32'h0);
    chk("rst_w_write_reg", 32'(w_write_reg), 32'h0);
    chk("rst_w_reg_write", 32'(w_reg_write), 32'h0);
    chk("rst_w_mem_to_reg", 32'(w_mem_to_reg), 32'h0);
    chk("rst_dreq_addr", dreq_addr, 32'h0);
    chk("rst_dreq_strobe", 32'(dreq_strobe), 32'h0);
    chk("rst_dreq_data", dreq_data, 32'h0);
    advance();

    // Table vectors: issue, then observe stage outputs, then writeback.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].alu, vecs[i].wdata, vecs[i].wreg, vecs[i].regw, vecs[i].load,
            vecs[i].store, vecs[i].br, vecs[i].zero, vecs[i].target);
      dresp_data_ok = 1'b0;
      settle_check();
      advance();
      e_valid       = 1'b0;
      dresp_data_ok = 1'b1;
      dresp_data    = vecs[i].rdata;
      settle_check();
      chk({vecs[i].name, "_dreq_valid"}, 32'(dreq_valid), 32'(vecs[i].x_dvalid));
      if (vecs[i].x_dvalid) begin
        chk({vecs[i].name, "_dreq_addr"}, dreq_addr, vecs[i].x_addr);
        chk({vecs[i].name, "_strobe"}, 32'(dreq_strobe), 32'(vecs[i].x_strobe));
      end
      chk({vecs[i].name, "_m_stall"}, 32'(m_stall), 32'h0);
      chk({vecs[i].name, "_pc_src"}, 32'(pc_src), 32'(vecs[i].x_pc_src));
      if (vecs[i].x_pc_src) chk({vecs[i].name, "_pc_branch"}, pc_branch, vecs[i].target);
      chk({vecs[i].name, "_fwd_aluout"}, fwd_aluout, vecs[i].alu);
      advance();
      dresp_data_ok = 1'b0;
      dresp_data    = 32'hCAFE_0000;
      settle_check();
      chk({vecs[i].name, "_w_valid"}, 32'(w_valid), 32'h1);
      chk({vecs[i].name, "_w_alu_result"}, w_alu_result, vecs[i].alu);
      chk({vecs[i].name, "_w_read_data"}, w_read_data, vecs[i].x_w_rd);
      chk({vecs[i].name, "_w_mem_to_reg"}, 32'(w_mem_to_reg), 32'(vecs[i].x_w_m2r));
      chk({vecs[i].name, "_pc_src_after"}, 32'(pc_src), 32'h0);
      advance();
    end

    // Store with three stall cycles; an ALU op waits behind it.
    drive(1'b1, 32'h2000, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    settle_check();
    advance();
    drive(1'b1, 32'h77, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      dresp_data_ok = (c == 4);
      settle_check();
      chk("st_dreq_valid", 32'(dreq_valid), 32'h1);
      chk("st_dreq_addr", dreq_addr, 32'h2000);
      chk("st_dreq_strobe", 32'(dreq_strobe), 32'hF);
      chk("st_dreq_data", dreq_data, 32'hA5A5_A5A5);
      chk("st_m_stall", 32'(m_stall), (c == 4) ? 32'h0 : 32'h1);
      if (c > 1) chk("st_w_bubble", 32'(w_valid), 32'h0);
      advance();
    end
    e_valid       = 1'b0;
    dresp_data_ok = 1'b0;
    settle_check();
    chk("st_w_valid", 32'(w_valid), 32'h1);
    chk("st_w_alu_result", w_alu_result, 32'h2000);
    chk("st_w_read_data", w_read_data, 32'h0);
    chk("st_next_fwd", fwd_aluout, 32'h77);
    chk("st_no_err", 32'(bus_err), 32'h0);
    advance();
    settle_check();
    advance();

    // Withheld data_ok: timeout after LIMIT wait cycles, then reset mid-wait.
    drive(1'b1, 32'h3000, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    settle_check();
    advance();
    e_valid       = 1'b0;
    dresp_data_ok = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      settle_check();
      advance();
      #1;
      chk("to_bus_err", 32'(bus_err), (k >= 5) ? 32'h1 : 32'h0);
      chk("to_dreq_valid", 32'(dreq_valid), 32'h1);
    end
    reset = 1'b1;
    model_reset();
    settle_check();
    chk("rw_dreq_valid", 32'(dreq_valid), 32'h0);
    chk("rw_m_stall", 32'(m_stall), 32'h0);
    chk("rw_w_valid", 32'(w_valid), 32'h0);
    chk("rw_bus_err", 32'(bus_err), 32'h0);
    advance();
    advance();
    reset = 1'b0;
    drive(1'b1, 32'h55, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    settle_check();
    advance();
    e_valid = 1'b0;
    settle_check();
    chk("rr_fwd_aluout", fwd_aluout, 32'h55);
    advance();
    settle_check();
    chk("rr_w_valid", 32'(w_valid), 32'h1);
    chk("rr_w_alu_result", w_alu_result, 32'h55);
    chk("rr_w_write_reg", 32'(w_write_reg), 32'h3);
    advance();

    // Random traffic with bounded bus latency.
    for (int n = 0; n < 400; n++) begin
      int unsigned k;
      k = $urandom % 4;
      drive(($urandom % 4) != 0, $urandom, $urandom, 5'($urandom),
            (k == 0) || (k == 1), k == 1, k == 2, k == 3, 1'($urandom), $urandom);
      dresp_data    = $urandom;
      dresp_data_ok = mdl_mem() && ((stall_run >= 2) || (($urandom % 3) == 0));
      settle_check();
      advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
